// File: rtl/clock_pkg.sv
// rtl/clock_pkg.sv - shared BCD types, limits and conversion helpers for the time counter
//
// Purpose : types and helpers used by bcd_time_counter and bcd_mod_counter.
// Contents: bcd2_t (two BCD digits {tens, units}), SEC_MAX/MIN_MAX/HOUR_MAX,
//           bin_to_bcd2 (elaboration-time conversion of reset values),
//           hour24_to_12 (24h BCD hour -> {pm, 12h BCD hour}).
package clock_pkg;

  typedef logic [7:0] bcd2_t;

  localparam bcd2_t SEC_MAX  = 8'h59;
  localparam bcd2_t MIN_MAX  = 8'h59;
  localparam bcd2_t HOUR_MAX = 8'h23;

  // Binary 0..99 to two BCD digits.
  function automatic bcd2_t bin_to_bcd2(input int unsigned v);
    int unsigned t;
    int unsigned u;
    t = v / 10;
    u = v % 10;
    return {t[3:0], u[3:0]};
  endfunction

  // Returns {pm, hour} where hour is the 12-hour BCD form (01..12).
  function automatic logic [8:0] hour24_to_12(input bcd2_t h);
    logic [4:0] hb;
    logic [4:0] h12;
    logic       pm_f;
    logic [3:0] t;
    logic [3:0] u;
    hb   = 5'(h[7:4]) * 5'd10 + 5'(h[3:0]);
    pm_f = (hb >= 5'd12);
    if (hb == 5'd0)
      h12 = 5'd12;
    else if (hb > 5'd12)
      h12 = hb - 5'd12;
    else
      h12 = hb;
    t = (h12 >= 5'd10) ? 4'd1 : 4'd0;
    u = 4'(h12 - ((h12 >= 5'd10) ? 5'd10 : 5'd0));
    return {pm_f, t, u};
  endfunction

endpackage

// File: rtl/bcd_mod_counter.sv
// rtl/bcd_mod_counter.sv - two-digit BCD modulo counter (00..MAX) with load and carry
//
// Purpose : one time field (seconds, minutes or hours) counted directly in BCD.
// Ports   : clk, rst_n (async active-low)
//           load     - synchronous load of load_val (wins over inc)
//           load_val - value loaded when load = 1
//           inc      - advance by one, wrapping MAX -> 00
//           value    - current BCD value
//           carry    - combinational; inc asserted while value == MAX
module bcd_mod_counter
  import clock_pkg::*;
#(
  parameter bcd2_t MAX       = 8'h59,
  parameter bcd2_t RESET_VAL = 8'h00
) (
  input  logic  clk,
  input  logic  rst_n,
  input  logic  load,
  input  bcd2_t load_val,
  input  logic  inc,
  output bcd2_t value,
  output logic  carry
);

  assign carry = inc && (value == MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value <= RESET_VAL;
    end else if (load) begin
      value <= load_val;
    end else if (inc) begin
      if (value == MAX)
        value <= 8'h00;
      else if (value[3:0] == 4'd9)
        value <= {value[7:4] + 4'd1, 4'd0};
      else
        value <= {value[7:4], value[3:0] + 4'd1};
    end
  end

endmodule

// File: rtl/bcd_time_counter.sv
// rtl/bcd_time_counter.sv - 1 Hz prescaler and BCD HH:MM:SS clock with 12/24h display
//
// Purpose : divides clk to a 1 Hz tick, keeps 24h BCD time, drives a 7-segment mux.
// Ports   : clk, rst_n (async active-low), en (run enable), mode_12h (display mode)
//           hour_inc / min_inc / sec_clr - single-cycle set pulses
//           hour_bcd - displayed hour (24h or 12h), pm - hour >= 12
//           min_bcd, sec_bcd - BCD minute/second
//           dp_led - high during the first half of each second
//           sec_tick - one-cycle pulse aligned with each new seconds value
module bcd_time_counter
  import clock_pkg::*;
#(
  parameter int TICKS_PER_SEC = 50_000_000,
  parameter int RESET_HOUR    = 0,
  parameter int RESET_MIN     = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       mode_12h,
  input  logic       hour_inc,
  input  logic       min_inc,
  input  logic       sec_clr,
  output logic [7:0] hour_bcd,
  output logic [7:0] min_bcd,
  output logic [7:0] sec_bcd,
  output logic       pm,
  output logic       dp_led,
  output logic       sec_tick
);

  localparam int              PW             = $clog2(TICKS_PER_SEC);
  localparam logic [PW-1:0]   PRE_LAST       = PW'(TICKS_PER_SEC - 1);
  localparam logic [PW-1:0]   PRE_HALF       = PW'(TICKS_PER_SEC / 2);
  localparam bcd2_t           RESET_HOUR_BCD = bin_to_bcd2(RESET_HOUR);
  localparam bcd2_t           RESET_MIN_BCD  = bin_to_bcd2(RESET_MIN);
  localparam logic            RESET_PM       = (RESET_HOUR >= 12);

  logic [PW-1:0] presc;
  logic [PW-1:0] presc_next;
  logic          term;
  logic          set_any;
  logic          tick;
  logic          sec_clear;
  bcd2_t         sec_val;
  bcd2_t         min_val;
  bcd2_t         hour_val;
  logic          sec_carry;
  logic          min_carry;
  logic          hour_carry_unused;
  logic [8:0]    hour_disp12;

  // Any set pulse swallows a coinciding tick; the prescaler still wraps.
  always_comb begin
    term       = en && (presc == PRE_LAST);
    set_any    = hour_inc | min_inc | sec_clr;
    tick       = term && !set_any;
    sec_clear  = min_inc | sec_clr;
    presc_next = presc;
    if (sec_clear)
      presc_next = '0;
    else if (en)
      presc_next = term ? '0 : presc + PW'(1);
  end

  bcd_mod_counter #(.MAX(SEC_MAX), .RESET_VAL(8'h00)) u_sec (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (sec_clear),
    .load_val (8'h00),
    .inc      (tick),
    .value    (sec_val),
    .carry    (sec_carry)
  );

  // sec_carry only fires on a real tick, so it never coincides with min_inc.
  bcd_mod_counter #(.MAX(MIN_MAX), .RESET_VAL(RESET_MIN_BCD)) u_min (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (1'b0),
    .load_val (8'h00),
    .inc      (min_inc | sec_carry),
    .value    (min_val),
    .carry    (min_carry)
  );

  // A user minute step wrapping 59 -> 00 must not carry into the hour.
  bcd_mod_counter #(.MAX(HOUR_MAX), .RESET_VAL(RESET_HOUR_BCD)) u_hour (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (1'b0),
    .load_val (8'h00),
    .inc      (hour_inc | (min_carry & ~min_inc)),
    .value    (hour_val),
    .carry    (hour_carry_unused)
  );

  assign hour_disp12 = hour24_to_12(hour_val);
  assign sec_bcd     = sec_val;
  assign min_bcd     = min_val;

  // dp_led is driven from the next prescaler value so it always matches
  // the prescaler register it is shown alongside.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc    <= '0;
      sec_tick <= 1'b0;
      dp_led   <= 1'b1;
      hour_bcd <= RESET_HOUR_BCD;
      pm       <= RESET_PM;
    end else begin
      presc    <= presc_next;
      sec_tick <= tick;
      dp_led   <= (presc_next < PRE_HALF);
      pm       <= hour_disp12[8];
      hour_bcd <= mode_12h ? hour_disp12[7:0] : hour_val;
    end
  end

endmodule
